// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CODE_W-1:0] req0_code,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CODE_W-1:0] req1_code,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_br_taken,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_br_taken,
  output logic [CODE_W-1:0] alu_code,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_br_taken
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t              r_state, w_next;
  logic                r_prio, r_owner, r_br;
  logic [DATA_W-1:0]   r_res;
  logic                w_gnt, w_acc, w_done;
  always_comb begin
    w_gnt      = (req0_valid && req1_valid) ? r_prio : req1_valid;
    req0_ready = rst_n && r_state == IDLE && req0_valid && !w_gnt;
    req1_ready = rst_n && r_state == IDLE && req1_valid && w_gnt;
    w_acc      = req0_ready || req1_ready;
    w_done     = r_state == RESP && (r_owner ? rsp1_ready : rsp0_ready);
    w_next     = r_state == IDLE ? (w_acc ? EXEC : IDLE) :
                 r_state == EXEC ? RESP : (w_done ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Operands are captured only at the grant, so requesters may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      alu_code <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_owner  <= w_gnt;
        alu_code <= w_gnt ? req1_code : req0_code;
        alu_op1  <= w_gnt ? req1_op1 : req0_op1;
        alu_op2  <= w_gnt ? req1_op2 : req0_op2;
      end
      if (r_state == EXEC) begin
        r_res <= alu_result;
        r_br  <= alu_br_taken;
      end
      if (w_done) r_prio <= ~r_owner;
    end
  end
  assign rsp0_valid    = r_state == RESP && !r_owner;
  assign rsp1_valid    = r_state == RESP && r_owner;
  assign rsp0_result   = r_res;
  assign rsp1_result   = r_res;
  assign rsp0_br_taken = r_br;
  assign rsp1_br_taken = r_br;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, SLL = 6'd2, SLTU = 6'd3, BEQ = 6'd4, JAL = 6'd5;
  logic        clk = 1'b0, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_code, req1_code, alu_code;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_valid, rsp0_ready, rsp0_br_taken, rsp1_valid, rsp1_ready, rsp1_br_taken;
  logic [31:0] rsp0_result, rsp1_result, alu_op1, alu_op2, alu_result;
  logic        alu_br_taken;
  int          n_chk = 0, n_pass = 0, cyc = 0, at, last;
  logic        m_busy, m_owner, m_age, m_prio, m_br;
  logic [5:0]  m_code;
  logic [31:0] m_op1, m_op2, m_res;

  alu_arbiter #(.DATA_W(32), .CODE_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_br_taken(rsp0_br_taken),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_br_taken(rsp1_br_taken),
    .alu_code(alu_code), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_br_taken(alu_br_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_fn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ADD:     return {1'b0, a + b};
      SUB:     return {1'b0, a - b};
      SLL:     return {1'b0, a << b[4:0]};
      SLTU:    return {1'b0, 31'd0, a < b};
      BEQ:     return {a == b, 32'd0};
      JAL:     return {1'b1, b + 32'd4};
      default: return 33'd0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  always_comb {alu_br_taken, alu_result} = alu_fn(alu_code, alu_op1, alu_op2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_prio = 0; m_br = 0;
    m_code = 0; m_op1 = 0; m_op2 = 0; m_res = 0;
  endtask

  // One cycle: compare DUT against the model, then advance the model across the edge.
  task automatic step();
    logic g, e_r0, e_r1, e_v0, e_v1;
    #1;
    g    = (req0_valid && req1_valid) ? m_prio : req1_valid;
    e_r0 = rst_n && !m_busy && req0_valid && !g;
    e_r1 = rst_n && !m_busy && req1_valid && g;
    e_v0 = m_busy && m_age && !m_owner;
    e_v1 = m_busy && m_age && m_owner;
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("rsp0_valid", rsp0_valid, e_v0);
    check("rsp1_valid", rsp1_valid, e_v1);
    check("alu_code", alu_code, m_code);
    check("alu_op1", alu_op1, m_op1);
    check("alu_op2", alu_op2, m_op2);
    if (e_v0) begin
      check("rsp0_result", rsp0_result, m_res);
      check("rsp0_br", rsp0_br_taken, m_br);
    end
    if (e_v1) begin
      check("rsp1_result", rsp1_result, m_res);
      check("rsp1_br", rsp1_br_taken, m_br);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else if (e_r0 || e_r1) begin
      m_busy = 1; m_owner = e_r1; m_age = 0;
      m_code = e_r1 ? req1_code : req0_code;
      m_op1  = e_r1 ? req1_op1 : req0_op1;
      m_op2  = e_r1 ? req1_op2 : req0_op2;
      {m_br, m_res} = alu_fn(m_code, m_op1, m_op2);
    end else if (m_busy && !m_age) m_age = 1;
    else if (m_busy && (m_owner ? rsp1_ready : rsp0_ready)) begin
      m_busy = 0; m_prio = !m_owner;
    end
    @(negedge clk);
  endtask

  task automatic expect_rsp(input logic p, input logic [31:0] res, input logic br, output int when);
    logic found;
    found = 0;
    when  = -1;
    for (int i = 0; i < 8 && !found; i++) begin
      #1;
      if (p ? rsp1_valid : rsp0_valid) begin
        found = 1;
        when  = cyc;
        check(p ? "exp_rsp1_result" : "exp_rsp0_result", p ? rsp1_result : rsp0_result, res);
        check(p ? "exp_rsp1_br" : "exp_rsp0_br", p ? rsp1_br_taken : rsp0_br_taken, br);
      end
      step();
    end
    check("rsp_timeout", found, 1);
  endtask

  task automatic req0(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_code = c; req0_op1 = a; req0_op2 = b;
  endtask

  task automatic req1(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_code = c; req1_op1 = a; req1_op2 = b;
  endtask

  initial begin
    rst_n = 0; rsp0_ready = 1; rsp1_ready = 1;
    req0(0, 0, 0, 0); req1(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_alu_op1", alu_op1, 0);
    // single request on port 0
    req0(1, ADD, 34, 55);
    #1 check("t1_req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    expect_rsp(0, 89, 0, at);
    // tie after reset, then alternation
    rst_n = 0; step(); rst_n = 1;
    req0(1, SUB, 55, 56); req1(1, BEQ, 32'hBAADF00D, 32'hBAADF00D);
    expect_rsp(0, 32'hFFFFFFFF, 0, at);
    expect_rsp(1, 0, 1, at);
    expect_rsp(0, 32'hFFFFFFFF, 0, at);
    expect_rsp(1, 0, 1, at);
    req0_valid = 0; req1_valid = 0;
    // operand change after acceptance
    req0(1, SLL, 32'hFEEDFACE, 1036);
    step();
    req0(0, ADD, 32'h12345678, 7);
    expect_rsp(0, 32'hDFACE000, 0, at);
    // back-pressured response on port 1 with port 0 waiting
    rsp1_ready = 0;
    req1(1, JAL, 0, 32'h40000);
    step();
    req1_valid = 0;
    req0(1, ADD, 1, 2);
    repeat (6) step();
    #1;
    check("t3_hold_valid", rsp1_valid, 1);
    check("t3_hold_result", rsp1_result, 32'h40004);
    check("t3_hold_br", rsp1_br_taken, 1);
    rsp1_ready = 1;
    step();
    #1 check("t3_req0_after", req0_ready, 1);
    step();
    req0_valid = 0;
    expect_rsp(0, 3, 0, at);
    // reset during EXEC discards the op and restores port-0 priority
    req0(1, ADD, 7, 8);
    step();
    req0_valid = 0; rst_n = 0;
    step();
    rst_n = 1;
    #1;
    check("t5_rsp0_valid", rsp0_valid, 0);
    check("t5_rsp1_valid", rsp1_valid, 0);
    req0(1, ADD, 1, 1); req1(1, ADD, 2, 2);
    #1 check("t5_tie_port0", req0_ready, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    expect_rsp(0, 2, 0, at);
    // streaming on port 0: one result every 3 cycles
    req0(1, SLTU, 32'hBADCAB1E, 32'hFEEDFACE);
    last = -1;
    for (int k = 0; k < 4; k++) begin
      expect_rsp(0, 1, 0, at);
      if (k > 0) check("t6_gap", at - last, 3);
      last = at;
    end
    req0_valid = 0;
    step();
    // random traffic, including occasional resets
    repeat (400) begin
      req0($urandom_range(0, 2) != 0, 6'($urandom_range(0, 5)), $urandom, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40));
      req1($urandom_range(0, 2) != 0, 6'($urandom_range(0, 5)), $urandom, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40));
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      rst_n      = $urandom_range(0, 63) != 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
